instr_mem_resp: RTL
===================

INSTR_MEM_RESP -- requirements
Module: instr_mem_resp

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- AW, 5, fetch/load address width.
- DW, 8, instruction word width.
- DEPTH, 32, number of words; SHALL equal 2**AW.
- WAIT_CYCLES, 2, wait states inserted before each response; legal range 0..15.

REQ-002 The module SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, reset; asynchronous, active-low.
- req, in, 1, CPU fetch request; sampled only in IDLE.
- addr, in, AW, fetch address; sampled together with req.
- rvalid, out, 1, one-cycle pulse marking rdata valid.
- rdata, out, DW, fetched instruction word.
- busy, out, 1, high whenever state is not IDLE.
- ld_we, in, 1, program-load write strobe.
- ld_addr, in, AW, program-load address.
- ld_data, in, DW, program-load data.
- ld_err, out, 1, one-cycle pulse flagging a load write rejected while busy.
- fetch_cnt, out, 8, count of completed responses; wraps 255 -> 0.

Function
REQ-003 Storage SHALL be DEPTH x DW registers, cleared to 8'h00 by reset.
REQ-004 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-005 In IDLE with req=1, the module SHALL latch addr and go to WAIT if WAIT_CYCLES>0, else go directly to RESP.
REQ-006 In IDLE with req=0, the module SHALL remain in IDLE.
REQ-007 On entering WAIT, a wait counter SHALL load WAIT_CYCLES-1 and decrement each cycle; the FSM SHALL go to RESP in the cycle after the counter reads 0.
REQ-008 In RESP, rvalid SHALL be 1 for exactly one cycle; rdata SHALL equal mem[latched addr] as read in that cycle; the FSM SHALL then return to IDLE.
REQ-009 Latency SHALL be WAIT_CYCLES+1 cycles from the clock edge that samples req to the cycle rvalid is high; back-to-back fetches SHALL have at least one IDLE cycle between them.
REQ-010 req asserted in WAIT or RESP SHALL be ignored; it is not queued.
REQ-011 rdata SHALL hold its last value while rvalid=0.
REQ-012 ld_we=1 in IDLE SHALL write ld_data to mem[ld_addr] at that edge.
REQ-013 ld_we=1 while busy=1 SHALL NOT write memory, and ld_err SHALL pulse high in the following cycle.
REQ-014 If ld_we and req occur together in IDLE, the write SHALL complete, and a fetch to the same address SHALL return the newly written data.
REQ-015 fetch_cnt SHALL increment by 1 on every RESP cycle, wrapping modulo 256.
REQ-016 busy SHALL be a direct decode of state (not IDLE); it SHALL be glitch-free and registered-state based.

Reset
REQ-017 When reset=0, the module SHALL immediately, independent of clk, force state=IDLE, rvalid=0, rdata=8'h00, busy=0, ld_err=0, fetch_cnt=0, wait counter=0, and all memory words to 8'h00.
REQ-018 Reset asserted mid-fetch (WAIT or RESP) SHALL abort the fetch with no rvalid pulse.
REQ-019 Operation SHALL resume on the first rising edge after reset returns to 1.

Verification
REQ-020 Reset check: reset=0 with ld_we/req toggling -> all outputs 0; fetch of addr 3 after release -> rdata=8'h00.
REQ-021 Load/fetch check (WAIT_CYCLES=2): load mem[5]=8'hA7 in IDLE, then req with addr=5 at edge T -> rvalid=1 and rdata=8'hA7 at T+3, busy high T+1..T+3, fetch_cnt=1.
REQ-022 Rejected load check: ld_we with ld_addr=5, ld_data=8'h11 during WAIT -> ld_err pulses one cycle; a refetch of addr 5 returns 8'hA7.
REQ-023 Simultaneous load/fetch check: in IDLE, ld_we (addr 9, data 8'h3C) with req (addr 9) -> rdata=8'h3C; req held high through WAIT yields exactly one rvalid.
REQ-024 Wrap and abort check: 256 fetches -> fetch_cnt=0; then reset=0 during WAIT -> no rvalid, state IDLE.
REQ-025 Zero-wait check (WAIT_CYCLES=0): req at edge T -> rvalid at T+1; the FSM never enters WAIT.

Source files
------------

// File: rtl/instr_mem_resp.sv
// Instruction memory with a fixed-latency fetch port and a program-load write port.
// Loads are accepted only while idle; a fetch answers WAIT_CYCLES+1 cycles after its request.
module instr_mem_resp #(
   parameter int AW          = 5,
   parameter int DW          = 8,
   parameter int DEPTH       = 32,
   parameter int WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic [AW-1:0] addr,
   output logic          rvalid,
   output logic [DW-1:0] rdata,
   output logic          busy,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   output logic          ld_err,
   output logic [7:0]    fetch_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WC_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

   state_t        r_state;
   state_t        w_next;
   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_addr;
   logic [3:0]    r_wcnt;
   logic [DW-1:0] r_rdata;
   logic          r_ld_err;
   logic [7:0]    r_fetch_cnt;
   logic          w_idle;
   logic          w_start;
   logic [DW-1:0] w_rd_word;

   assign w_idle    = (r_state == IDLE);
   assign w_start   = w_idle && req;
   assign w_rd_word = r_mem[r_addr];

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (req) begin
               if (WAIT_CYCLES > 0) w_next = WAIT;
               else                 w_next = RESP;
            end
         end
         WAIT:    if (r_wcnt == '0) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr <= '0;
         r_wcnt <= '0;
      end else begin
         if (w_start) begin
            r_addr <= addr;
            r_wcnt <= WC_LOAD;
         end else if (r_state == WAIT && r_wcnt != '0) begin
            r_wcnt <= r_wcnt - 4'd1;
         end
      end
   end

   // Writes are blocked while a fetch is in flight so the response word cannot change under it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= '0;
      end else if (ld_we && w_idle) begin
         r_mem[ld_addr] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ld_err    <= 1'b0;
         r_rdata     <= '0;
         r_fetch_cnt <= '0;
      end else begin
         r_ld_err <= ld_we && !w_idle;
         if (r_state == RESP) begin
            r_rdata     <= w_rd_word;
            r_fetch_cnt <= r_fetch_cnt + 8'd1;
         end
      end
   end

   // During RESP the word is presented straight from memory; otherwise the last response is held.
   assign rvalid    = (r_state == RESP);
   assign rdata     = rvalid ? w_rd_word : r_rdata;
   assign busy      = !w_idle;
   assign ld_err    = r_ld_err;
   assign fetch_cnt = r_fetch_cnt;

endmodule
